// File: rtl/multisum_pipe.sv
// multisum_pipe: pipelined NUM_IN-operand unsigned adder tree with an
// optional running-accumulate output stage and a sticky overflow flag.
// Tree levels are WIDTH+LEVELS bits wide, so no carry is lost before the
// output stage. That stage decides between wrapping and saturating.
module multisum_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_IN   = 3,
    parameter int unsigned SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic                      in_acc,
    input  logic                      ovf_clr,
    output logic                      sum_valid,
    output logic [WIDTH-1:0]          sum,
    output logic                      ovf
);

    localparam int unsigned LEVELS = $clog2(NUM_IN);
    localparam int unsigned TW     = WIDTH + LEVELS;

    logic [TW-1:0]     in_ext [NUM_IN];
    logic [TW-1:0]     tree_d [LEVELS][NUM_IN];
    logic [TW-1:0]     tree_q [LEVELS][NUM_IN];
    logic [LEVELS-1:0] vld_q;
    logic [LEVELS-1:0] tag_q;

    logic [TW-1:0]     tree_res;
    logic [TW:0]       acc_term;
    logic [TW:0]       raw;
    logic              over;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        assign in_ext[i] = {{LEVELS{1'b0}}, in_data[i*WIDTH +: WIDTH]};
    end

    // Each level pairs up the entries of the level below it. An odd leftover
    // entry passes straight through, and unused slots are tied to zero.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned SRC_CNT = (NUM_IN + (1 << l) - 1) >> l;
        for (genvar j = 0; j < NUM_IN; j++) begin : g_node
            if (2*j + 1 < SRC_CNT) begin : g_add
                if (l == 0) begin : g_src_in
                    assign tree_d[l][j] = in_ext[2*j] + in_ext[2*j+1];
                end else begin : g_src_lvl
                    assign tree_d[l][j] = tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
                end
            end else if (2*j < SRC_CNT) begin : g_pass
                if (l == 0) begin : g_src_in
                    assign tree_d[l][j] = in_ext[2*j];
                end else begin : g_src_lvl
                    assign tree_d[l][j] = tree_q[l-1][2*j];
                end
            end else begin : g_unused
                assign tree_d[l][j] = '0;
            end
        end
    end

    // Tree data registers. The data is don't-care whenever the valid bit is low,
    // so these registers have no reset.
    always_ff @(posedge clk) begin
        tree_q <= tree_d;
    end

    // Valid and accumulate-tag bits move through the tree alongside the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            tag_q[0] <= in_acc;
            for (int unsigned l = 1; l < LEVELS; l++) begin
                vld_q[l] <= vld_q[l-1];
                tag_q[l] <= tag_q[l-1];
            end
        end
    end

    // Take the full-width result, optionally add the current sum to it, and
    // detect any bit above WIDTH.
    always_comb begin
        tree_res = tree_q[LEVELS-1][0];
        acc_term = '0;
        if (tag_q[LEVELS-1]) begin
            acc_term = {{(LEVELS+1){1'b0}}, sum};
        end
        raw  = {1'b0, tree_res} + acc_term;
        over = |raw[TW:WIDTH];
    end

    // Output register. The overflow set takes priority over a clear that
    // arrives on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_valid <= 1'b0;
            sum       <= '0;
            ovf       <= 1'b0;
        end else begin
            sum_valid <= vld_q[LEVELS-1];
            if (vld_q[LEVELS-1]) begin
                if (over && (SATURATE != 0)) begin
                    sum <= '1;
                end else begin
                    sum <= raw[WIDTH-1:0];
                end
            end
            if (vld_q[LEVELS-1] && over) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
